sensor_avg_seq: RTL

SENSOR_AVG_SEQ -- requirements
Module: sensor_avg_seq

---
 rtl/sensor_avg_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sensor_avg_seq.sv
// Sensor averaging sequencer: snapshots all channels, accumulates the enabled ones
// one per cycle, then divides sum by count with a bit-serial restoring divider.
module sensor_avg_seq #(
  parameter  int N_SENSORS = 5,
  parameter  int DATA_W    = 8,
  localparam int SUM_W     = (N_SENSORS > 1) ? DATA_W + $clog2(N_SENSORS) : DATA_W + 1,
  localparam int CNT_W     = $clog2(N_SENSORS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [N_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [N_SENSORS-1:0]        sensors_en_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [SUM_W-1:0]            temp_sum_o,
  output logic [CNT_W-1:0]            nr_active_sensors_o,
  output logic [DATA_W-1:0]           temp_avg_o,
  output logic                        no_sensor_o
);
  // One step counter serves both the channel walk and the divider bit count.
  localparam int STEP_MAX = (N_SENSORS > SUM_W) ? N_SENSORS : SUM_W;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

  state_t                      r_state, w_state_next;
  logic [N_SENSORS*DATA_W-1:0] r_data;
  logic [N_SENSORS-1:0]        r_en;
  logic [STEP_W-1:0]           r_idx;
  logic [SUM_W-1:0]            r_sum, r_quo;
  logic [CNT_W-1:0]            r_cnt, r_rem;
  logic                        r_valid, r_no_sensor;
  logic [SUM_W-1:0]            r_sum_out;
  logic [CNT_W-1:0]            r_cnt_out;
  logic [DATA_W-1:0]           r_avg_out;

  logic [DATA_W-1:0] w_ch_val;
  logic              w_ch_en, w_last_ch, w_last_bit, w_fits;
  logic [SUM_W-1:0]  w_sum_acc;
  logic [CNT_W-1:0]  w_cnt_acc;
  logic [CNT_W:0]    w_trial, w_diff;

  always_comb begin
    w_ch_val = '0;
    w_ch_en  = 1'b0;
    for (int k = 0; k < N_SENSORS; k++) begin
      if (r_idx == STEP_W'(k)) begin
        w_ch_val = r_data[k*DATA_W +: DATA_W];
        w_ch_en  = r_en[k];
      end
    end
  end

  assign w_sum_acc  = r_sum + (w_ch_en ? SUM_W'(w_ch_val) : '0);
  assign w_cnt_acc  = r_cnt + CNT_W'(w_ch_en);
  assign w_last_ch  = (r_idx == STEP_W'(N_SENSORS - 1));
  assign w_last_bit = (r_idx == STEP_W'(SUM_W - 1));
  // Partial remainder stays below the divisor, so CNT_W+1 bits hold the trial value.
  assign w_trial    = {r_rem, r_quo[SUM_W-1]};
  assign w_fits     = (w_trial >= {1'b0, r_cnt});
  assign w_diff     = w_trial - {1'b0, r_cnt};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_next = ACCUM;
      ACCUM:   if (w_last_ch) w_state_next = (w_cnt_acc != '0) ? DIV : DONE;
      DIV:     if (w_last_bit) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data      <= '0;
      r_en        <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_valid     <= 1'b0;
      r_no_sensor <= 1'b0;
      r_sum_out   <= '0;
      r_cnt_out   <= '0;
      r_avg_out   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_data <= sensors_data_i;
            r_en   <= sensors_en_i;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
          end
        end
        ACCUM: begin
          r_sum <= w_sum_acc;
          r_cnt <= w_cnt_acc;
          if (w_last_ch) begin
            r_idx <= '0;
            r_quo <= w_sum_acc;
            r_rem <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DIV: begin
          r_quo <= {r_quo[SUM_W-2:0], w_fits};
          r_rem <= w_fits ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
          r_idx <= r_idx + 1'b1;
        end
        DONE: begin
          // Mean never exceeds the largest channel, so the low DATA_W quotient bits suffice.
          r_sum_out   <= r_sum;
          r_cnt_out   <= r_cnt;
          r_avg_out   <= r_quo[DATA_W-1:0];
          r_no_sensor <= (r_cnt == '0);
          r_valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o              = (r_state != IDLE);
  assign valid_o             = r_valid;
  assign temp_sum_o          = r_sum_out;
  assign nr_active_sensors_o = r_cnt_out;
  assign temp_avg_o          = r_avg_out;
  assign no_sensor_o         = r_no_sensor;
endmodule
